// File: rtl/fc_requant_serializer_if.sv
// Stream bundle for fc_requant_serializer: parallel accumulator capture on one
// side, one requantized lane per transfer on the other.
interface fc_requant_serializer_if #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  // Both sides use valid/ready: a beat moves on a rising clk edge where valid
  // and ready are both high; valid never waits on ready, and the payload is
  // held stable while valid is high and ready is low.
  logic                         in_valid;
  logic signed [ACC_WIDTH-1:0]  in_data [NUM_NEURONS];
  logic                         in_ready;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]             out_index;
  logic                         out_last;
  logic                         out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fc_requant_serializer.sv
// Captures an FC accumulator vector, requantizes every lane in parallel
// (round half up, optional ReLU, saturate) and replays the lanes one per beat.
module fc_requant_serializer #(
  parameter int NUM_NEURONS = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int FRAC_BITS   = 8,
  parameter int APPLY_RELU  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fc_requant_serializer_if.slave   s,
  output logic                     overflow_err,
  output logic [15:0]              sat_count,
  output logic                     state_dbg
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W = $clog2(NUM_NEURONS + 1);
  localparam int SAT_W = 16;
  localparam logic signed [ACC_WIDTH:0] ROUND = (ACC_WIDTH + 1)'(1) <<< (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] MAXV =
    {{(ACC_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MINV =
    {{(ACC_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                       state, state_nxt;
  logic [1:0]                   rst_sync;
  logic                         rst_int_n;
  logic signed [DATA_WIDTH-1:0] buf_q [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] rq    [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       clip;
  logic [CNT_W-1:0]             clip_cnt;
  logic [SAT_W:0]               sat_sum;
  logic [SAT_W-1:0]             sat_nxt;
  logic [IDX_W-1:0]             idx_q;
  logic                         last, xfer, capture, in_ready_c;

  // Reset asserts asynchronously but is released only after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // The sum is one bit wider than the accumulator so the rounding bias never wraps.
  function automatic logic [DATA_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH:0] t;
    logic signed [ACC_WIDTH:0] r;
    logic [DATA_WIDTH-1:0]     q;
    logic                      clipped;
    t = {acc[ACC_WIDTH-1], acc} + ROUND;
    r = t >>> FRAC_BITS;
    if ((APPLY_RELU != 0) && r[ACC_WIDTH]) r = '0;
    clipped = 1'b0;
    if (r > MAXV) begin
      q = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
      clipped = 1'b1;
    end else if (r < MINV) begin
      q = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
      clipped = 1'b1;
    end else begin
      q = r[DATA_WIDTH-1:0];
    end
    return {clipped, q};
  endfunction

  always_comb begin
    clip     = '0;
    clip_cnt = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      {clip[i], rq[i]} = requant(s.in_data[i]);
      clip_cnt = clip_cnt + CNT_W'(clip[i]);
    end
    sat_sum = {1'b0, sat_count} + (SAT_W + 1)'(clip_cnt);
    sat_nxt = sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
  end

  always_comb begin
    last       = (idx_q == IDX_W'(NUM_NEURONS - 1));
    xfer       = (state == STREAM) && s.out_ready;
    in_ready_c = (state == IDLE) || (xfer && last);
    capture    = s.in_valid && in_ready_c;
    state_nxt  = state;
    case (state)
      IDLE:    if (capture) state_nxt = STREAM;
      STREAM:  if (xfer && last) state_nxt = capture ? STREAM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state        <= IDLE;
      idx_q        <= '0;
      overflow_err <= 1'b0;
      sat_count    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) buf_q[i] <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        buf_q     <= rq;
        idx_q     <= '0;
        sat_count <= sat_nxt;
      end else if (xfer && !last) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (s.in_valid && !in_ready_c) overflow_err <= 1'b1;
    end
  end

  // Index is left on the final lane after a vector, so out_data holds its last value.
  assign s.in_ready  = in_ready_c;
  assign s.out_valid = (state == STREAM);
  assign s.out_data  = buf_q[idx_q];
  assign s.out_index = idx_q;
  assign s.out_last  = (state == STREAM) && last;
  assign state_dbg   = state;
endmodule

// File: doc/fc_requant_serializer.md
Name: fc_requant_serializer

Overview:
- Sits directly downstream of an FC layer wrapper: captures its parallel accumulator vector on the valid pulse.
- Requantizes each lane from ACC_WIDTH fixed point back to DATA_WIDTH: round, optional ReLU, saturate.
- Replays the lanes one per cycle as a valid/ready stream, ready to drive the next FC layer's serial input.

Parameters:
- NUM_NEURONS, 16: lanes per input vector.
- DATA_WIDTH, 16: output sample width, signed.
- ACC_WIDTH, 32: input accumulator width, signed.
- FRAC_BITS, 8: right-shift applied to each accumulator; must be ≥ 1.
- APPLY_RELU, 1: 1 clamps negative results to 0; 0 passes signed values through.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  one-cycle vector-valid pulse from the FC layer.
- in_data  in  NUM_NEURONS x ACC_WIDTH (unpacked array [NUM_NEURONS], signed)  accumulator vector.
- in_ready  out  1  block can capture a vector this cycle.
- out_valid  out  1  out_data holds a valid sample.
- out_data  out  DATA_WIDTH signed  requantized sample.
- out_index  out  $clog2(NUM_NEURONS)  lane number of the current sample.
- out_last  out  1  current sample is lane NUM_NEURONS-1.
- out_ready  in  1  downstream accepts the sample.
- overflow_err  out  1  sticky: a vector arrived while in_ready was low.
- sat_count  out  16  saturating count of lanes clipped by saturation.

Behaviour:
- Reset (async assert, sync deassert inside block): state IDLE, out_valid=0, out_data=0, out_index=0, out_last=0, overflow_err=0, sat_count=0, buffer cleared. Mid-stream reset discards all remaining lanes immediately.
- States:
  - IDLE: in_ready=1.
  - STREAM: out_valid=1.
- Capture: in_valid && in_ready at edge N.
  - All NUM_NEURONS lanes are requantized in parallel and registered into the buffer.
  - State goes to STREAM and the lane counter goes to 0.
  - out_valid=1 with lane 0 from cycle N+1. Latency is 1 cycle.
- Requant per lane:
  - t = in_data + 2^(FRAC_BITS-1), computed in ACC_WIDTH+1 bits, so there is no wrap.
  - r = t >>> FRAC_BITS (arithmetic shift). This is round-half-up: -1.5 gives -1, 3.5 gives 4.
  - If APPLY_RELU and r<0, then r=0.
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Each clipped lane increments sat_count by 1; sat_count holds at 0xFFFF.
- Stream:
  - out_data, out_index and out_last stay stable while out_valid && !out_ready.
  - Each transfer (out_valid && out_ready) advances the lane counter by 1.
  - The transfer on lane NUM_NEURONS-1 (out_last=1) returns the state to IDLE, unless a new capture happens in the same cycle.
- Back-to-back: in_ready = IDLE || (out_valid && out_ready && out_last), combinational.
  - A capture coinciding with the final transfer reloads the buffer and restarts at lane 0 on the next cycle.
  - This gives zero bubble between vectors when downstream never stalls.
- Drop rule: in_valid && !in_ready sets overflow_err (sticky until reset). The incoming vector is discarded and the stream in progress is unaffected.
- Transitions:
  - IDLE→STREAM on capture.
  - STREAM→IDLE on the last transfer without capture.
  - STREAM→STREAM on the last transfer with capture.
  - Any state→IDLE on reset.
- out_data when out_valid=0: holds its last value (don't-care for the consumer).

Test Plan:
- APPLY_RELU=1, lane0=0x00000380, lane1=0xFFFFFF00, other lanes=k*256 -> out_valid one cycle after capture; stream is 4, 0, then k for lanes 2..15; out_last only on index 15; then IDLE with in_ready=1.
- APPLY_RELU=0, lanes 0x7FFFFFFF, 0x80000000, 0xFFFFFE80 -> outputs 32767, -32768, -1; sat_count=2.
- out_ready toggles 1,0,0,1 pattern throughout a vector -> every lane delivered exactly once, in order; out_data, out_index and out_last stable across stall cycles.
- out_ready=1 always, second in_valid coincident with the index-15 transfer -> second vector's lane 0 on the next cycle, no bubble, overflow_err stays 0.
- in_valid pulse at index 5 of an active stream -> overflow_err=1 and stays 1; current stream continues unchanged through index 15; dropped vector never appears.
- rst_n asserted asynchronously at index 7, between clock edges -> out_valid, overflow_err and sat_count go to 0 immediately; after release a fresh vector streams from index 0.
